// File: rtl/rv_pkg.sv
// Shared RV32I fetch-stage types and defaults: PC-unit state and next-PC select encodings.
package rv_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_HOLD     = 3'd0,
        SEL_INC      = 3'd1,
        SEL_REDIRECT = 3'd2,
        SEL_TRAP     = 3'd3,
        SEL_RET      = 3'd4
    } pc_sel_t;

    // Any non-sequential PC change kills the instructions already in IF/ID.
    function automatic logic is_flush_sel(input pc_sel_t sel);
        logic flush_v;
        case (sel)
            SEL_REDIRECT, SEL_TRAP, SEL_RET: flush_v = 1'b1;
            default:                         flush_v = 1'b0;
        endcase
        return flush_v;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC arbitration: fixed event priority plus redirect-target alignment check.
module pc_next_sel
    import rv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int IALIGN = 4
) (
    input  logic            run,
    input  logic            fetch_valid,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic            trap_return,
    output pc_sel_t         sel,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    logic target_misaligned_s;

    assign target_misaligned_s = |(redirect_target & ALIGN_MASK);

    // Priority: trap > trap_return > redirect > stall > advance; nothing happens outside RUN.
    always_comb begin
        sel        = SEL_HOLD;
        misaligned = 1'b0;
        if (!run) begin
            sel = SEL_HOLD;
        end else if (trap) begin
            sel = SEL_TRAP;
        end else if (trap_return) begin
            sel = SEL_RET;
        end else if (redirect_valid) begin
            if (target_misaligned_s) begin
                sel        = SEL_TRAP;
                misaligned = 1'b1;
            end else begin
                sel = SEL_REDIRECT;
            end
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (fetch_valid && fetch_ready) begin
            sel = SEL_INC;
        end else begin
            sel = SEL_HOLD;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// RV32I program-counter unit: fetch handshake, stall, redirect, trap entry/return,
// misaligned-target trapping and a one-cycle IF/ID flush pulse.
module pc_unit
    import rv_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int              PC_INC       = 4,
    parameter int              IALIGN       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            trap,
    input  logic            trap_return,
    output logic [XLEN-1:0] fetch_pc,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] badaddr,
    output logic            misaligned,
    output logic            flush
);

    pc_state_t       state_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic            fetch_valid_r;
    logic [XLEN-1:0] epc_r;
    logic [XLEN-1:0] badaddr_r;
    logic            misaligned_r;
    logic            flush_r;

    pc_sel_t         sel_s;
    logic            misaligned_s;
    logic [XLEN-1:0] pc_plus_inc_s;

    assign pc_plus_inc_s = fetch_pc_r + XLEN'(PC_INC);

    pc_next_sel #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_next_sel (
        .run             (state_r == RUN),
        .fetch_valid     (fetch_valid_r),
        .fetch_ready     (fetch_ready),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap            (trap),
        .trap_return     (trap_return),
        .sel             (sel_s),
        .misaligned      (misaligned_s)
    );

    // FSM, PC/EPC/badaddr registers and the registered flush/misaligned pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= BOOT;
            fetch_pc_r    <= RESET_VECTOR;
            fetch_valid_r <= 1'b0;
            epc_r         <= '0;
            badaddr_r     <= '0;
            misaligned_r  <= 1'b0;
            flush_r       <= 1'b0;
        end else begin
            misaligned_r <= misaligned_s;
            flush_r      <= is_flush_sel(sel_s);

            case (state_r)
                BOOT: begin
                    state_r       <= RUN;
                    fetch_valid_r <= 1'b1;
                end
                RUN: begin
                    state_r       <= RUN;
                    fetch_valid_r <= 1'b1;
                end
                default: begin
                    state_r       <= BOOT;
                    fetch_valid_r <= 1'b0;
                end
            endcase

            case (sel_s)
                SEL_INC:      fetch_pc_r <= pc_plus_inc_s;
                SEL_REDIRECT: fetch_pc_r <= redirect_target;
                SEL_TRAP: begin
                    // A misaligned redirect is folded into trap entry; only it records badaddr.
                    fetch_pc_r <= TRAP_VECTOR;
                    epc_r      <= ex_pc;
                    if (misaligned_s) begin
                        badaddr_r <= redirect_target;
                    end else begin
                        badaddr_r <= badaddr_r;
                    end
                end
                SEL_RET:      fetch_pc_r <= epc_r;
                default:      fetch_pc_r <= fetch_pc_r;
            endcase
        end
    end

    assign fetch_pc    = fetch_pc_r;
    assign fetch_valid = fetch_valid_r;
    assign pc_plus_inc = pc_plus_inc_s;
    assign epc         = epc_r;
    assign badaddr     = badaddr_r;
    assign misaligned  = misaligned_r;
    assign flush       = flush_r;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: IALIGN=4 and IALIGN=2 instances share stimulus and are compared
// against a behavioural next-PC model plus directed expectations.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, fetch_ready, redirect_valid, trap, trap_return;
    logic [31:0] redirect_target, ex_pc;

    logic [31:0] a_fetch_pc, a_pc_plus_inc, a_epc, a_badaddr;
    logic        a_fetch_valid, a_misaligned, a_flush;
    logic [31:0] b_fetch_pc, b_pc_plus_inc, b_epc, b_badaddr;
    logic        b_fetch_valid, b_misaligned, b_flush;

    int n_cmp = 0;
    int n_err = 0;

    // model state, index 0 -> IALIGN 4, index 1 -> IALIGN 2
    logic [31:0] m_pc [2];
    logic [31:0] m_epc [2];
    logic [31:0] m_bad [2];
    bit          m_run [2];
    bit          m_mis [2];
    bit          m_fl  [2];

    always #5 clk = ~clk;

    pc_unit #(.IALIGN(4)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target), .ex_pc(ex_pc),
        .trap(trap), .trap_return(trap_return),
        .fetch_pc(a_fetch_pc), .fetch_valid(a_fetch_valid), .pc_plus_inc(a_pc_plus_inc),
        .epc(a_epc), .badaddr(a_badaddr), .misaligned(a_misaligned), .flush(a_flush)
    );

    pc_unit #(.IALIGN(2)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target), .ex_pc(ex_pc),
        .trap(trap), .trap_return(trap_return),
        .fetch_pc(b_fetch_pc), .fetch_valid(b_fetch_valid), .pc_plus_inc(b_pc_plus_inc),
        .epc(b_epc), .badaddr(b_badaddr), .misaligned(b_misaligned), .flush(b_flush)
    );

    // Apply one clock edge to the model using the inputs presented before it.
    task automatic model_edge();
        int align;
        for (int k = 0; k < 2; k++) begin
            align = (k == 0) ? 4 : 2;
            if (rst) begin
                m_pc[k] = 32'h0; m_epc[k] = 32'h0; m_bad[k] = 32'h0;
                m_run[k] = 1'b0; m_mis[k] = 1'b0; m_fl[k] = 1'b0;
            end else if (!m_run[k]) begin
                m_run[k] = 1'b1; m_mis[k] = 1'b0; m_fl[k] = 1'b0;
            end else begin
                m_mis[k] = 1'b0; m_fl[k] = 1'b0;
                if (trap) begin
                    m_pc[k] = 32'h100; m_epc[k] = ex_pc; m_fl[k] = 1'b1;
                end else if (trap_return) begin
                    m_pc[k] = m_epc[k]; m_fl[k] = 1'b1;
                end else if (redirect_valid) begin
                    m_fl[k] = 1'b1;
                    if (redirect_target % align == 0) begin
                        m_pc[k] = redirect_target;
                    end else begin
                        m_pc[k] = 32'h100; m_epc[k] = ex_pc;
                        m_bad[k] = redirect_target; m_mis[k] = 1'b1;
                    end
                end else if (fetch_ready && !stall) begin
                    m_pc[k] = m_pc[k] + 32'd4;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0; trap = 1'b0;
        trap_return = 1'b0; redirect_target = 32'h0; ex_pc = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs();
        step(); step();
        rst = 1'b0;
        n_cmp++;
        if ({a_fetch_pc, a_fetch_valid, a_epc, a_badaddr, a_misaligned, a_flush} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_state: pc=%h fv=%b epc=%h bad=%h mis=%b fl=%b, want all zero", a_fetch_pc, a_fetch_valid, a_epc, a_badaddr, a_misaligned, a_flush);
        end
        step();
        n_cmp++;
        if ({a_fetch_pc, a_fetch_valid} !== {32'h0, 1'b1}) begin
            n_err++; $display("FAIL boot_exit: pc=%h fv=%b, want 00000000/1", a_fetch_pc, a_fetch_valid);
        end
        step();
        n_cmp++;
        if (a_fetch_pc !== 32'h4) begin n_err++; $display("FAIL advance_4: pc=%h want 00000004", a_fetch_pc); end
        step();
        n_cmp++;
        if (a_fetch_pc !== 32'h8) begin n_err++; $display("FAIL advance_8: pc=%h want 00000008", a_fetch_pc); end
    endtask

    task automatic test_backpressure();
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({a_fetch_pc, a_fetch_valid} !== {32'h8, 1'b1}) begin
                n_err++; $display("FAIL not_ready_hold: pc=%h fv=%b want 00000008/1", a_fetch_pc, a_fetch_valid);
            end
        end
        fetch_ready = 1'b1;
        step();
        n_cmp++;
        if (a_fetch_pc !== 32'hC) begin n_err++; $display("FAIL ready_resume: pc=%h want 0000000c", a_fetch_pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({a_fetch_pc, a_fetch_valid} !== {32'hC, 1'b1}) begin
                n_err++; $display("FAIL stall_hold: pc=%h fv=%b want 0000000c/1", a_fetch_pc, a_fetch_valid);
            end
        end
        stall = 1'b0;
        step();
        n_cmp++;
        if (a_fetch_pc !== 32'h10) begin n_err++; $display("FAIL stall_resume: pc=%h want 00000010", a_fetch_pc); end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hDEADBEEC;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        n_cmp++;
        if ({a_fetch_pc, a_flush, a_misaligned} !== {32'hDEADBEEC, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL redirect_stall: pc=%h fl=%b mis=%b want deadbeec/1/0", a_fetch_pc, a_flush, a_misaligned);
        end
        step();
        n_cmp++;
        if ({a_fetch_pc, a_flush} !== {32'hDEADBEF0, 1'b0}) begin
            n_err++; $display("FAIL redirect_advance: pc=%h fl=%b want deadbef0/0", a_fetch_pc, a_flush);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_target = 32'hDEADBEEF; ex_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if ({a_fetch_pc, a_epc, a_badaddr, a_misaligned, a_flush} !== {32'h100, 32'h40, 32'hDEADBEEF, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL misaligned_trap: pc=%h epc=%h bad=%h mis=%b fl=%b want 00000100/00000040/deadbeef/1/1", a_fetch_pc, a_epc, a_badaddr, a_misaligned, a_flush);
        end
        step();
        n_cmp++;
        if ({a_fetch_pc, a_misaligned, a_flush} !== {32'h104, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL misaligned_clear: pc=%h mis=%b fl=%b want 00000104/0/0", a_fetch_pc, a_misaligned, a_flush);
        end
        redirect_valid = 1'b1; redirect_target = 32'h12345676; ex_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if ({b_fetch_pc, b_misaligned, b_flush} !== {32'h12345676, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL ialign2_accept: pc=%h mis=%b fl=%b want 12345676/0/1", b_fetch_pc, b_misaligned, b_flush);
        end
        n_cmp++;
        if ({a_fetch_pc, a_badaddr, a_misaligned} !== {32'h100, 32'h12345676, 1'b1}) begin
            n_err++; $display("FAIL ialign4_reject: pc=%h bad=%h mis=%b want 00000100/12345676/1", a_fetch_pc, a_badaddr, a_misaligned);
        end
    endtask

    task automatic test_trap_return();
        trap = 1'b1; ex_pc = 32'h12345678;
        step();
        trap = 1'b0;
        n_cmp++;
        if ({a_fetch_pc, a_epc, a_flush} !== {32'h100, 32'h12345678, 1'b1}) begin
            n_err++; $display("FAIL trap_entry: pc=%h epc=%h fl=%b want 00000100/12345678/1", a_fetch_pc, a_epc, a_flush);
        end
        step();
        trap_return = 1'b1;
        step();
        trap_return = 1'b0;
        n_cmp++;
        if ({a_fetch_pc, a_flush} !== {32'h12345678, 1'b1}) begin
            n_err++; $display("FAIL trap_return: pc=%h fl=%b want 12345678/1", a_fetch_pc, a_flush);
        end
        trap = 1'b1; trap_return = 1'b1; redirect_valid = 1'b1;
        redirect_target = 32'h2000; ex_pc = 32'hCAFE0000;
        step();
        trap = 1'b0; trap_return = 1'b0; redirect_valid = 1'b0;
        n_cmp++;
        if ({a_fetch_pc, a_epc, a_flush} !== {32'h100, 32'hCAFE0000, 1'b1}) begin
            n_err++; $display("FAIL trap_priority: pc=%h epc=%h fl=%b want 00000100/cafe0000/1", a_fetch_pc, a_epc, a_flush);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if ({a_fetch_pc, a_pc_plus_inc} !== {32'hFFFFFFFC, 32'h0}) begin
            n_err++; $display("FAIL wrap_top: pc=%h inc=%h want fffffffc/00000000", a_fetch_pc, a_pc_plus_inc);
        end
        step();
        n_cmp++;
        if (a_fetch_pc !== 32'h0) begin n_err++; $display("FAIL wrap_zero: pc=%h want 00000000", a_fetch_pc); end
    endtask

    task automatic test_mid_reset();
        step();
        rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h3000;
        step();
        rst = 1'b0; redirect_valid = 1'b0;
        n_cmp++;
        if ({a_fetch_pc, a_fetch_valid, a_flush} !== {32'h0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL mid_reset: pc=%h fv=%b fl=%b want 00000000/0/0", a_fetch_pc, a_fetch_valid, a_flush);
        end
        trap = 1'b1; ex_pc = 32'h44;
        step();
        trap = 1'b0;
        n_cmp++;
        if ({a_fetch_pc, a_fetch_valid, a_flush, a_epc} !== {32'h0, 1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL boot_ignores_trap: pc=%h fv=%b fl=%b epc=%h want 00000000/1/0/00000000", a_fetch_pc, a_fetch_valid, a_flush, a_epc);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            trap           = ($urandom_range(0, 15) == 0);
            trap_return    = ($urandom_range(0, 11) == 0);
            redirect_valid = ($urandom_range(0, 4) == 0);
            stall          = ($urandom_range(0, 3) == 0);
            fetch_ready    = ($urandom_range(0, 3) != 0);
            r = $urandom();
            redirect_target = ($urandom_range(0, 1) == 0) ? {r[31:2], 2'b00} : r;
            ex_pc          = $urandom() & 32'hFFFF_FFFC;
            step();
            n_cmp++;
            if ({a_fetch_pc, a_fetch_valid, a_pc_plus_inc, a_epc, a_badaddr, a_misaligned, a_flush}
                !== {m_pc[0], m_run[0], m_pc[0] + 32'd4, m_epc[0], m_bad[0], m_mis[0], m_fl[0]}) begin
                n_err++;
                $display("FAIL random_a[%0d]: got pc=%h fv=%b inc=%h epc=%h bad=%h mis=%b fl=%b want pc=%h fv=%b epc=%h bad=%h mis=%b fl=%b",
                         i, a_fetch_pc, a_fetch_valid, a_pc_plus_inc, a_epc, a_badaddr, a_misaligned, a_flush,
                         m_pc[0], m_run[0], m_epc[0], m_bad[0], m_mis[0], m_fl[0]);
            end
            n_cmp++;
            if ({b_fetch_pc, b_fetch_valid, b_pc_plus_inc, b_epc, b_badaddr, b_misaligned, b_flush}
                !== {m_pc[1], m_run[1], m_pc[1] + 32'd4, m_epc[1], m_bad[1], m_mis[1], m_fl[1]}) begin
                n_err++;
                $display("FAIL random_b[%0d]: got pc=%h fv=%b inc=%h epc=%h bad=%h mis=%b fl=%b want pc=%h fv=%b epc=%h bad=%h mis=%b fl=%b",
                         i, b_fetch_pc, b_fetch_valid, b_pc_plus_inc, b_epc, b_badaddr, b_misaligned, b_flush,
                         m_pc[1], m_run[1], m_epc[1], m_bad[1], m_mis[1], m_fl[1]);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0; m_epc[k] = 32'h0; m_bad[k] = 32'h0;
            m_run[k] = 1'b0; m_mis[k] = 1'b0; m_fl[k] = 1'b0;
        end
        rst = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_backpressure();
        test_redirect_over_stall();
        test_misaligned();
        test_trap_return();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
